// File: rtl/pipeline_ctrl_if.sv
// Bundle of signals between the pipeline latch chain and its hazard controller.
//   fd_instr, dx_instr : instructions held in the F/D and D/X latches
//   branch_taken       : X-stage branch/jump resolved taken this cycle
//   md_ready           : mult/div result valid this cycle
//   pc_en, fd_en, dx_en: PC / latch write enables
//   fd_flush           : F/D latch loads nop this edge
//   dx_bubble          : D/X latch loads nop this edge
//   xm_bubble          : X/M latch loads nop this edge
//   md_start           : one-cycle start pulse to the mult/div unit
//   md_timeout         : one-cycle pulse when the watchdog forces completion
//   stall_cnt          : saturating count of stalled cycles
//   flush_cnt          : saturating count of taken-branch flushes
// master = datapath side (supplies instructions and status);
// slave  = the controller (returns enables and counters).
interface pipeline_ctrl_if;
  logic [31:0] fd_instr;
  logic [31:0] dx_instr;
  logic        branch_taken;
  logic        md_ready;
  logic        pc_en;
  logic        fd_en;
  logic        dx_en;
  logic        fd_flush;
  logic        dx_bubble;
  logic        xm_bubble;
  logic        md_start;
  logic        md_timeout;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output fd_instr, dx_instr, branch_taken, md_ready,
    input  pc_en, fd_en, dx_en, fd_flush, dx_bubble, xm_bubble,
           md_start, md_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  fd_instr, dx_instr, branch_taken, md_ready,
    output pc_en, fd_en, dx_en, fd_flush, dx_bubble, xm_bubble,
           md_start, md_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the F/D, D/X and X/M pipeline latches.
// Decodes the D-stage (fd_instr) and X-stage (dx_instr) instructions and
// produces latch enables, bubbles and flushes for:
//   - load-use interlock (one-cycle stall with a D/X bubble)
//   - taken-branch flush of the F/D latch plus a D/X bubble
//   - multi-cycle mult/div stall with start/ready handshake and watchdog
// Ports:
//   clock : single clock, all state updates on posedge
//   reset : synchronous, active-high
//   bus   : pipeline_ctrl_if.slave (instructions/status in, controls/counters out)
// Control outputs are combinational from state and inputs; the FSM state,
// watchdog and the two event counters are registered.
// CNT_W must satisfy 2**CNT_W > MD_TIMEOUT.
module pipeline_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic           clock,
  input  logic           reset,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic {IDLE, MD_WAIT} state_t;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MD_TIMEOUT - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wdog, wdog_nxt;
  logic [15:0]      stall_cnt_q, flush_cnt_q;

  logic pc_en, fd_en, dx_en, fd_flush, dx_bubble, xm_bubble, md_start, md_timeout;

  // Instruction fields
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_aluop;
  logic       dx_lw, dx_md, load_use;
  logic       use_rs, use_rt, use_rd;

  assign fd_op    = bus.fd_instr[31:27];
  assign fd_rd    = bus.fd_instr[26:22];
  assign fd_rs    = bus.fd_instr[21:17];
  assign fd_rt    = bus.fd_instr[16:12];
  assign dx_op    = bus.dx_instr[31:27];
  assign dx_rd    = bus.dx_instr[26:22];
  assign dx_aluop = bus.dx_instr[6:2];

  logic unused_bits;
  assign unused_bits = ^{bus.fd_instr[11:0], bus.dx_instr[21:7], bus.dx_instr[1:0]};

  assign dx_lw = (dx_op == OP_LW) && (dx_rd != 5'd0);
  assign dx_md = (dx_op == OP_RTYPE) && ((dx_aluop == ALU_MUL) || (dx_aluop == ALU_DIV));

  // Which register fields the D-stage instruction actually reads
  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    use_rd = 1'b0;
    case (fd_op)
      5'b00000: begin use_rs = 1'b1; use_rt = 1'b1; end
      5'b00101: use_rs = 1'b1;
      5'b01000: use_rs = 1'b1;
      5'b00111: begin use_rs = 1'b1; use_rd = 1'b1; end
      5'b00010: begin use_rs = 1'b1; use_rd = 1'b1; end
      5'b00110: begin use_rs = 1'b1; use_rd = 1'b1; end
      5'b00100: use_rd = 1'b1;
      default: ;
    endcase
  end

  // r0 can never match because dx_lw already excludes a load into r0
  assign load_use = dx_lw && ((use_rs && (fd_rs == dx_rd)) ||
                              (use_rt && (fd_rt == dx_rd)) ||
                              (use_rd && (fd_rd == dx_rd)));

  always_comb begin
    state_nxt  = state;
    wdog_nxt   = wdog;
    pc_en      = 1'b1;
    fd_en      = 1'b1;
    dx_en      = 1'b1;
    fd_flush   = 1'b0;
    dx_bubble  = 1'b0;
    xm_bubble  = 1'b0;
    md_start   = 1'b0;
    md_timeout = 1'b0;
    if (reset) begin
      // Abandon any in-flight mult/div silently; outputs stay at defaults
      state_nxt = IDLE;
      wdog_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (dx_md) begin
            md_start  = 1'b1;
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            xm_bubble = 1'b1;
            state_nxt = MD_WAIT;
            wdog_nxt  = '0;
          end else if (load_use) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_bubble = 1'b1;
          end else if (bus.branch_taken) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
          end
        end
        MD_WAIT: begin
          if (bus.md_ready || (wdog >= WDOG_LAST)) begin
            // Result (real or forced) passes into X/M with all enables open
            state_nxt  = IDLE;
            md_timeout = ~bus.md_ready;
          end else begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            xm_bubble = 1'b1;
            wdog_nxt  = wdog + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wdog        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      wdog  <= wdog_nxt;
      if (!pc_en)   stall_cnt_q <= sat_inc(stall_cnt_q);
      if (fd_flush) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign bus.pc_en      = pc_en;
  assign bus.fd_en      = fd_en;
  assign bus.dx_en      = dx_en;
  assign bus.fd_flush   = fd_flush;
  assign bus.dx_bubble  = dx_bubble;
  assign bus.xm_bubble  = xm_bubble;
  assign bus.md_start   = md_start;
  assign bus.md_timeout = md_timeout;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule
